// File: rtl/act_pkg.sv
// act_pkg: shared Q8.8 constants and FSM state encoding for the activation arbiter.
//   Q_ONE      Q8.8 value 1.0, the upper saturation output
//   Q_HALF     Q8.8 value 0.5, the sigmoid midpoint
//   SAT_LIMIT  |x| beyond which the sigmoid output saturates
//   state_e    arbiter FSM states
package act_pkg;

  localparam logic signed [15:0] Q_ONE     = 16'sh0100;
  localparam logic signed [15:0] Q_HALF    = 16'sh0080;
  localparam logic signed [15:0] SAT_LIMIT = 16'sd2048;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin grant selection, purely combinational.
//   req_valid  in   N_REQ  per-requester valid
//   rr_ptr     in   ID_W   highest-priority requester index
//   grant      out  ID_W   first valid index searching upward from rr_ptr, wrapping
//   any_valid  out  1      at least one requester is valid
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  grant,
  output logic             any_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr) + i) % N_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/sigmoid.sv
// sigmoid: piecewise-linear Q8.8 sigmoid approximation, purely combinational.
//   x  in   16  pre-activation, Q8.8 signed
//   y  out  16  activation, Q8.8 signed
// The saturation test is strict, so x = +/-2048 falls on the linear segment and
// yields 0x0180 / 0xFF80 rather than a clipped value.
module sigmoid
  import act_pkg::*;
(
  input  logic signed [15:0] x,
  output logic signed [15:0] y
);

  always_comb begin
    if (x > SAT_LIMIT) begin
      y = Q_ONE;
    end else if (x < -SAT_LIMIT) begin
      y = '0;
    end else begin
      // Arithmetic shift keeps the sign; the add wraps at 16 bits.
      y = Q_HALF + (x >>> 3);
    end
  end

endmodule

// File: rtl/activation_arbiter.sv
// activation_arbiter: shares one sigmoid unit between N_REQ requesters using
// round-robin arbitration and returns the result tagged with the requester ID.
//   clk, rst    clock, asynchronous active-high reset
//   req_valid   in   N_REQ         per-requester request valid
//   req_data    in   N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W], Q8.8 signed
//   req_ready   out  N_REQ         one-hot accept strobe, only in S_IDLE
//   resp_valid  out  1             result valid, held until resp_ready
//   resp_data   out  DATA_W        activated value, Q8.8 signed
//   resp_id     out  ID_W          requester owning resp_data
//   resp_ready  in   1             consumer accepts result
//   busy        out  1             FSM is not in S_IDLE
// Optional macro ACTIVATION_ARBITER_STATS_EN adds saturating counters:
//   sat_hi_cnt  out  16  evaluations with x > 2048
//   sat_lo_cnt  out  16  evaluations with x < -2048
module activation_arbiter
  import act_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic [ID_W-1:0]         resp_id,
  input  logic                    resp_ready,
  output logic                    busy
`ifdef ACTIVATION_ARBITER_STATS_EN
  ,
  output logic [15:0]             sat_hi_cnt,
  output logic [15:0]             sat_lo_cnt
`endif
);

  state_e                    state_q;
  logic [ID_W-1:0]           rr_ptr_q;
  logic [ID_W-1:0]           id_q;
  logic signed [DATA_W-1:0]  x_q;
  logic                      resp_valid_q;
  logic [DATA_W-1:0]         resp_data_q;
  logic [ID_W-1:0]           resp_id_q;

  logic [ID_W-1:0]           grant;
  logic                      any_valid;
  logic signed [DATA_W-1:0]  sig_y;

  rr_picker #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_rr_picker (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .any_valid(any_valid)
  );

  // The single shared activation unit; it only ever sees the latched operand.
  sigmoid u_sigmoid (
    .x(x_q),
    .y(sig_y)
  );

  // Accept strobe is combinational so the grant lands in the same cycle it is chosen.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == S_IDLE) && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

`ifdef ACTIVATION_ARBITER_STATS_EN
  logic [15:0] sat_hi_q;
  logic [15:0] sat_lo_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      x_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
`ifdef ACTIVATION_ARBITER_STATS_EN
      sat_hi_q     <= '0;
      sat_lo_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            x_q     <= req_data[grant*DATA_W +: DATA_W];
            id_q    <= grant;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          resp_data_q  <= sig_y;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= S_HOLD;
`ifdef ACTIVATION_ARBITER_STATS_EN
          if ((x_q > SAT_LIMIT) && (sat_hi_q != 16'hFFFF)) begin
            sat_hi_q <= sat_hi_q + 16'd1;
          end
          if ((x_q < -SAT_LIMIT) && (sat_lo_q != 16'hFFFF)) begin
            sat_lo_q <= sat_lo_q + 16'd1;
          end
`endif
        end
        S_HOLD: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            // Requester just served drops to lowest priority.
            rr_ptr_q     <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != S_IDLE);

`ifdef ACTIVATION_ARBITER_STATS_EN
  assign sat_hi_cnt = sat_hi_q;
  assign sat_lo_cnt = sat_lo_q;
`endif

endmodule

// File: tb/tb_activation_arbiter.sv
// tb_activation_arbiter: directed self-checking bench for activation_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_activation_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic        busy;
`ifdef ACTIVATION_ARBITER_STATS_EN
  logic [15:0] sat_hi_cnt;
  logic [15:0] sat_lo_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  activation_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .resp_ready(resp_ready),
    .busy      (busy)
`ifdef ACTIVATION_ARBITER_STATS_EN
    ,
    .sat_hi_cnt(sat_hi_cnt),
    .sat_lo_cnt(sat_lo_cnt)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_data   = 64'h0300_0200_0100_0000;
    resp_ready = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_req_ready got=%b want=0000", req_ready);
    end
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid);
    end
    vectors++;
    if (resp_data !== 16'h0000) begin
      miscompares++; $display("FAIL reset_resp_data got=%h want=0000", resp_data);
    end
    vectors++;
    if (resp_id !== 2'd0) begin
      miscompares++; $display("FAIL reset_resp_id got=%0d want=0", resp_id);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got=%b want=0", busy);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated request through the whole IDLE -> EVAL -> HOLD -> IDLE cycle.
  task automatic send(input int id, input logic [15:0] x, input logic [15:0] exp_y);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << id;
    @(negedge clk);
    req_valid = exp_rdy;
    req_data  = '0;
    req_data[id*16 +: 16] = x;
    #1;
    vectors++;
    if (req_ready !== exp_rdy) begin
      miscompares++; $display("FAIL send_req_ready x=%h got=%b want=%b", x, req_ready, exp_rdy);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    req_data  = '1;  // post-acceptance changes must not leak into the result
    vectors++;
    if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL send_eval x=%h got valid=%b busy=%b want valid=0 busy=1", x, resp_valid, busy);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== exp_y || resp_id !== 2'(id)) begin
      miscompares++;
      $display("FAIL send_resp x=%h got v=%b y=%h id=%0d want v=1 y=%h id=%0d",
               x, resp_valid, resp_data, resp_id, exp_y, id);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL send_done x=%h got valid=%b busy=%b want 0 0", x, resp_valid, busy);
    end
  endtask

  task automatic test_single();
    send(1, 16'h0100, 16'h00A0);
  endtask

  task automatic test_arith();
    send(0, 16'hFE00, 16'h0040);
    send(2, 16'h0BB8, 16'h0100);  // 3000
    send(3, 16'hF448, 16'h0000);  // -3000
    send(1, 16'h0800, 16'h0180);  // 2048, not clipped
    send(2, 16'hF800, 16'hFF80);  // -2048, not clipped
    send(0, 16'h0801, 16'h0100);  // 2049
    send(3, 16'hF7FF, 16'h0000);  // -2049
  endtask

  task automatic test_fairness();
    int exp;
    do_reset();
    req_valid  = 4'b1111;
    req_data   = 64'h0300_0200_0100_0000;
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = k % 4;
      #1;
      vectors++;
      if (req_ready !== (4'b0001 << exp)) begin
        miscompares++; $display("FAIL fair_grant k=%0d got=%b want id %0d", k, req_ready, exp);
      end
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++; $display("FAIL fair_eval_ready k=%0d got=%b want=0000", k, req_ready);
      end
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(exp) || resp_data !== 16'(16'h0080 + exp * 16'h0020)
          || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL fair_resp k=%0d got v=%b id=%0d y=%h rdy=%b want id=%0d", k, resp_valid,
                 resp_id, resp_data, req_ready, exp);
      end
      @(negedge clk);
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 4'b0101;
    req_data  = 64'h0000_FF00_0000_0200;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL bp_first_grant got=%b want=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== 16'h00C0 || resp_id !== 2'd0
          || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d got v=%b y=%h id=%0d rdy=%b want v=1 y=00c0 id=0 rdy=0000",
                 c, resp_valid, resp_data, resp_id, req_ready);
      end
      if (c < 5) @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL bp_exit_regrant got=%b want=0000", req_ready);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_next_grant got v=%b rdy=%b want v=0 rdy=0100", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h0060 || resp_id !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_second_resp got v=%b y=%h id=%0d want v=1 y=0060 id=2",
               resp_valid, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // rr_ptr is now 3; requester 2 alone still wins.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 64'h0000_0100_0000_0000;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL rm_grant got=%b want=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL rm_in_eval got busy=%b want=1", busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b0000 || resp_data !== 16'h0000
        || resp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rm_async got busy=%b v=%b rdy=%b y=%h id=%0d want all zero",
               busy, resp_valid, req_ready, resp_data, resp_id);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rm_no_resp got v=%b busy=%b want 0 0", resp_valid, busy);
    end
    req_valid = 4'b1111;
    req_data  = 64'h0300_0200_0100_0000;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL rm_ptr_cleared got=%b want=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h0080 || resp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rm_after_resp got v=%b y=%h id=%0d want v=1 y=0080 id=0",
               resp_valid, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

`ifdef ACTIVATION_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    vectors++;
    if (sat_hi_cnt !== 16'd0 || sat_lo_cnt !== 16'd0) begin
      miscompares++; $display("FAIL stats_reset got hi=%0d lo=%0d want 0 0", sat_hi_cnt, sat_lo_cnt);
    end
    send(0, 16'h0BB8, 16'h0100);
    send(1, 16'hF448, 16'h0000);
    send(2, 16'hF448, 16'h0000);
    send(3, 16'h0800, 16'h0180);
    vectors++;
    if (sat_hi_cnt !== 16'd1 || sat_lo_cnt !== 16'd2) begin
      miscompares++; $display("FAIL stats_count got hi=%0d lo=%0d want 1 2", sat_hi_cnt, sat_lo_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef ACTIVATION_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
